// File: rtl/seven_segment_scan_driver_if.sv
// seven_segment_scan_driver_if: load/value in, busy/done/digit/anode out for the scan driver
interface seven_segment_scan_driver_if #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
);
  logic                  i_load;
  logic [DATA_W-1:0]     i_data_in;
  logic                  o_busy;
  logic                  o_done;
  logic [3:0]            o_digit;
  logic [NUM_DIGITS-1:0] o_anode;
  modport master (output i_load, i_data_in, input o_busy, o_done, o_digit, o_anode);
  modport slave  (input i_load, i_data_in, output o_busy, o_done, o_digit, o_anode);
endinterface

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver: double-dabble binary->BCD into a display buffer, scanned one digit per slot; define LEADING_ZERO_BLANK_EN to blank leading zeros
module seven_segment_scan_driver #(
  parameter int DATA_W      = 16,
  parameter int NUM_DIGITS  = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  seven_segment_scan_driver_if.slave   bus
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                r_state, w_state_nxt;
  logic [DATA_W-1:0]     r_shift;
  logic [BW-1:0]         r_bcd, r_buf, w_adj, w_bcd_nxt;
  logic [CW-1:0]         r_cnt;
  logic                  r_done, w_busy, w_last;
  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [3:0]            r_digit, w_nib;
  logic [3:0]            w_nibs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_anode;
  genvar d;
  for (d = 0; d < NUM_DIGITS; d++) begin : g_nib
    assign w_adj[4*d +: 4] = r_bcd[4*d +: 4] >= 4'd5 ? r_bcd[4*d +: 4] + 4'd3 : r_bcd[4*d +: 4];
    assign w_nibs[d]       = r_buf[4*d +: 4];
  end
  assign w_bcd_nxt = (w_adj << 1) | BW'(r_shift[DATA_W-1]);
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz;
  for (d = 0; d < NUM_DIGITS; d++) begin : g_lz
    assign w_lz[d] = (d != 0) && (r_buf[BW-1:4*d] == '0);
  end
  assign w_nib = w_lz[w_idx_nxt] ? 4'hF : w_nibs[w_idx_nxt];
`else
  assign w_nib = w_nibs[w_idx_nxt];
`endif
  // conversion FSM state register
  always_ff @(posedge i_clk)
    r_state <= !i_rst_n ? IDLE : w_state_nxt;
  // next state: a load (re)starts a conversion, the final shift returns to idle
  always_comb
    w_state_nxt = bus.i_load ? SHIFT : w_last ? IDLE : r_state;
  // FSM outputs: busy while shifting, last on the final shift cycle
  always_comb begin
    w_busy = r_state == SHIFT;
    w_last = w_busy && r_cnt == CW'(1);
  end
  // shift-add-3 datapath; the buffer only takes a completed result
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) r_buf <= w_bcd_nxt;
      if (bus.i_load) begin
        r_shift <= bus.i_data_in;
        r_bcd   <= '0;
        r_cnt   <= CW'(DATA_W);
      end else if (w_busy) begin
        r_shift <= r_shift << 1;
        r_bcd   <= w_bcd_nxt;
        r_cnt   <= r_cnt - 1'b1;
      end
    end
  // next scan slot: advance on prescaler terminal count
  always_comb
    w_idx_nxt = r_pre != PW'(REFRESH_DIV - 1) ? r_idx : r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1;
  // free-running prescaler, slot index and registered digit/anode pair
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_digit <= '0;
      r_anode <= ~NUM_DIGITS'(1);
    end else begin
      r_pre   <= r_pre == PW'(REFRESH_DIV - 1) ? '0 : r_pre + 1'b1;
      r_idx   <= w_idx_nxt;
      r_digit <= w_nib;
      r_anode <= ~(NUM_DIGITS'(1) << w_idx_nxt);
    end
  assign bus.o_busy  = w_busy;
  assign bus.o_done  = r_done;
  assign bus.o_digit = r_digit;
  assign bus.o_anode = r_anode;
endmodule

// File: doc/seven_segment_scan_driver.md
Name: seven_segment_scan_driver

Overview:
- Upstream of the SevenSegment decoder.
- Converts a binary value to BCD with a sequential shift-add-3 (double-dabble) engine, holds the result in a display buffer, and time-multiplexes the digits.
- Each scan slot presents one 4-bit digit code, which feeds the decoder's numin, together with an active-low anode one-hot.
- Used to show register or PC values from the MIPS datapath on the board display.

Parameters:
- DATA_W, 16, binary input width; legal range 1..26.
- NUM_DIGITS, 5, BCD digits produced and scanned; must be >= ceil(DATA_W*0.30103); legal range 1..8.
- REFRESH_DIV, 100000, Clk cycles per scan slot; must be >= 2.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Rst  input  1  synchronous, active-low reset; sampled on rising Clk.
- Load  input  1  one-cycle strobe; captures DataIn and starts a conversion.
- DataIn  input  DATA_W  unsigned binary value to display.
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when the display buffer updates.
- DigitOut  output  4  BCD digit for the active slot (0..9); 4'hF means blank. Drives the decoder numin.
- AnodeOut  output  NUM_DIGITS  active-low digit enable; exactly one bit low at all times.

Behaviour:
- Reset (Rst=0 at a rising edge): Busy=0, Done=0, display buffer all zero, shift/BCD working regs=0, prescaler=0, scan index=0, DigitOut=4'h0, AnodeOut=~1 (only bit 0 low). Reset has priority over Load and aborts any conversion in flight; the buffer is cleared.
- Conversion FSM states: IDLE, SHIFT.
  - IDLE: Load=1 copies DataIn into the shift reg, clears the BCD working reg, sets the bit counter to DATA_W, goes to SHIFT. Busy=1 from the next cycle.
  - SHIFT, each cycle:
    - every BCD nibble >= 5 gets +3;
    - then {BCD, shift} shifts left 1;
    - the counter decrements.
  - SHIFT exit: on the cycle the counter reaches 0, the final BCD value is written to the display buffer. In that same cycle Done=1 and Busy=0, and the FSM returns to IDLE.
  - Latency: Load sampled at edge N -> buffer updated and Done high after edge N+DATA_W (exactly DATA_W cycles of Busy).
  - Load during SHIFT: the conversion restarts with the new DataIn. The counter reloads, no Done is issued for the aborted value, and the buffer keeps its previous contents.
  - Load in the same cycle as completion: the completing value is written and Done pulses; the new conversion then starts (Busy stays 1).
  - Width rule: the BCD working reg is 4*NUM_DIGITS bits. Max input 2^DATA_W-1 must convert exactly (16-bit: 65535 -> digits 6,5,5,3,5).
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1 continuously and runs independently of the conversion FSM.
  - At terminal count it wraps to 0 and the scan index advances (NUM_DIGITS-1 wraps to 0).
  - Index 0 is the least significant digit.
  - AnodeOut bit[index]=0, all others 1.
  - DigitOut = buffer nibble[index], or blank per the optional feature.
  - DigitOut and AnodeOut are registered and change on the same edge.
- The display always shows the buffer, never the working regs, so no partial values are visible during conversion.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined: for index>0, DigitOut=4'hF if nibble[index] and every more-significant nibble are all 0. Digit 0 is never blanked, so value 0 shows a single "0".
- When undefined: all NUM_DIGITS digits show their numeric value, including leading zeros.
- Anode scanning is identical in both builds.

Test Plan (bench uses REFRESH_DIV=4, DATA_W=16, NUM_DIGITS=5):
1. Reset test: hold Rst=0 for 3 cycles, then release -> Busy=0, Done=0, AnodeOut=5'b11110, DigitOut=0. After 4 cycles AnodeOut=5'b11101.
2. Conversion latency: Load with DataIn=16'd1234 -> Busy high exactly 16 cycles; Done pulses 1 cycle; buffer nibbles = 4,3,2,1,0. Scan shows DigitOut 4,3,2,1 then 0 (or F with LEADING_ZERO_BLANK_EN) on successive slots.
3. Boundary values: DataIn=16'hFFFF -> digits 5,3,5,5,6. DataIn=0 -> digit0=0; digits1..4 are 0 without the macro, F with it.
4. Load mid-conversion: Load 9999, then Load 42 eight cycles later -> only one Done, 16 cycles after the second Load; buffer shows 42; 9999 never appears.
5. Reset mid-operation: Rst=0 during SHIFT -> next cycle Busy=0, no Done, buffer all zero, AnodeOut=5'b11110.
6. Scan wrap: let 5 full slots elapse -> AnodeOut cycles 11110, 11101, 11011, 10111, 01111, 11110. Exactly one bit is low every cycle.
